// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to add per-requester accepted-beat counters (beat_count, stats_clear).
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int CNT_W      = 16,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          write_clk,
   input  logic                          write_rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_grant,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          full,
   output logic                          write_enable,
   output logic [DATA_WIDTH-1:0]         write_data,
   output logic [ID_W-1:0]               owner_id
`ifdef FIFO_ARB_STATS_EN
   ,
   input  logic                          stats_clear,
   output logic [NUM_REQ*CNT_W-1:0]      beat_count
`endif
);
   typedef enum logic {IDLE, BURST} state_t;
   state_t state, state_nxt;
   logic [NUM_REQ-1:0] grant_nxt;
   logic [ID_W-1:0] rr, rr_nxt, owner_nxt, win;
   logic [3:0] cnt, cnt_nxt;
   logic found, owner_valid;
   // first valid requester strictly after the rr pointer, wrapping
   always_comb begin
      win = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && req_valid[(int'(rr) + k) % NUM_REQ]) begin
            win = ID_W'((int'(rr) + k) % NUM_REQ);
            found = 1'b1;
         end
      end
   end
   assign owner_valid  = req_valid[owner_id];
   assign write_enable = (state == BURST) && owner_valid && !full && !write_rst;
   assign req_ready    = write_rst ? '0 : req_grant & {NUM_REQ{~full}};
   assign write_data   = (|req_grant) ? req_data[owner_id*DATA_WIDTH +: DATA_WIDTH] : '0;
   always_comb begin
      state_nxt = state;
      grant_nxt = req_grant;
      owner_nxt = owner_id;
      rr_nxt    = rr;
      cnt_nxt   = cnt;
      if (state == IDLE) begin
         if (found) begin
            state_nxt = BURST;
            owner_nxt = win;
            grant_nxt = NUM_REQ'(1) << win;
         end
      end else if (!full) begin
         // release on an idle owner or on the beat that completes the burst
         if (!owner_valid || cnt == 4'(MAX_BURST - 1)) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            owner_nxt = '0;
            rr_nxt    = owner_id;
            cnt_nxt   = '0;
         end else begin
            cnt_nxt = cnt + 4'd1;
         end
      end
   end
   always_ff @(posedge write_clk) begin
      if (write_rst) begin
         state     <= IDLE;
         req_grant <= '0;
         owner_id  <= '0;
         rr        <= ID_W'(NUM_REQ - 1);
         cnt       <= '0;
      end else begin
         state     <= state_nxt;
         req_grant <= grant_nxt;
         owner_id  <= owner_nxt;
         rr        <= rr_nxt;
         cnt       <= cnt_nxt;
      end
   end
`ifdef FIFO_ARB_STATS_EN
   always_ff @(posedge write_clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (write_rst || stats_clear)
            beat_count[i*CNT_W +: CNT_W] <= '0;
         else if (req_valid[i] && req_ready[i] && !(&beat_count[i*CNT_W +: CNT_W]))
            beat_count[i*CNT_W +: CNT_W] <= beat_count[i*CNT_W +: CNT_W] + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed bench for fifo_write_arbiter with hand-computed expectations.
module tb_fifo_write_arbiter;
   localparam int N = 4;
   localparam int DW = 8;
   logic write_clk = 1'b0;
   logic write_rst, full;
   logic [N-1:0] req_valid, req_grant, req_ready;
   logic [N*DW-1:0] req_data;
   logic write_enable;
   logic [DW-1:0] write_data;
   logic [1:0] owner_id;
`ifdef FIFO_ARB_STATS_EN
   logic stats_clear;
   logic [N*16-1:0] beat_count;
`endif
   int compared = 0, mismatched = 0;
   logic [7:0] mem [N][32];
   int hd [N], ln [N], st [N];
   int cyc, ncap;
   logic [7:0] cap [64];
   logic [1:0] cap_own [64];
   logic we_log [64];
   logic [3:0] gr_log [64], rdy_log [64];
   logic [1:0] own_log [64];
   logic [9:0] wv;

   always #5 write_clk = ~write_clk;

   fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4), .CNT_W(16)) dut (
      .write_clk(write_clk),
      .write_rst(write_rst),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_grant(req_grant),
      .req_ready(req_ready),
      .full(full),
      .write_enable(write_enable),
      .write_data(write_data),
      .owner_id(owner_id)
`ifdef FIFO_ARB_STATS_EN
      ,
      .stats_clear(stats_clear),
      .beat_count(beat_count)
`endif
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // one clock: drive inputs, sample at negedge, consume transferred beats, land 1 after posedge
   task automatic step(input logic f, input logic r);
      full = f;
      write_rst = r;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = (cyc >= st[i]) && (hd[i] < ln[i]);
         req_data[i*DW +: DW] = req_valid[i] ? mem[i][hd[i]] : 8'h00;
      end
      @(negedge write_clk);
      if (cyc < 64) begin
         we_log[cyc] = write_enable;
         gr_log[cyc] = req_grant;
         rdy_log[cyc] = req_ready;
         own_log[cyc] = owner_id;
      end
      if (write_enable && ncap < 64) begin
         cap[ncap] = write_data;
         cap_own[ncap] = owner_id;
         ncap++;
      end
      for (int i = 0; i < N; i++)
         if (req_valid[i] && req_ready[i]) hd[i]++;
      @(posedge write_clk);
      #1;
      cyc++;
   endtask

   task automatic src(input int i, input int n, input logic [7:0] first, input int inc, input int start);
      for (int k = 0; k < n; k++) mem[i][k] = 8'(int'(first) + k * inc);
      hd[i] = 0;
      ln[i] = n;
      st[i] = start;
   endtask

   task automatic do_reset();
      for (int i = 0; i < N; i++) begin
         hd[i] = 0;
         ln[i] = 0;
         st[i] = 0;
      end
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      cyc = 0;
      ncap = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      cyc = 0;
      ncap = 0;
      write_rst = 1'b1;
      full = 1'b0;
      req_valid = '0;
      req_data = '0;
`ifdef FIFO_ARB_STATS_EN
      stats_clear = 1'b0;
`endif
      // reset with every requester valid
      for (int i = 0; i < N; i++) src(i, 1, 8'h10 + 8'(i), 0, 0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check("rst_we0", we_log[0], 0);
      check("rst_gr0", gr_log[0], 0);
      check("rst_own0", own_log[0], 0);
      check("rst_rdy0", rdy_log[0], 0);
      check("rst_we1", we_log[1], 0);
      check("rst_gr1", gr_log[1], 0);
      step(1'b0, 1'b0);
      check("arb_cycle_gr", gr_log[2], 0);
      step(1'b0, 1'b0);
      check("first_grant", gr_log[3], 4'b0001);
      // single requester, burst split by MAX_BURST
      do_reset();
      src(2, 6, 8'h01, 1, 0);
      repeat (10) step(1'b0, 1'b0);
      check("t2_ncap", ncap, 6);
      for (int k = 0; k < 6; k++) begin
         check("t2_data", cap[k], k + 1);
         check("t2_own", cap_own[k], 2);
      end
      for (int k = 0; k < 10; k++) wv[k] = we_log[k];
      check("t2_we_pattern", wv, 10'b0011011110);
      check("t2_gap_gr", gr_log[5], 0);
      check("t2_regrant", gr_log[6], 4'b0100);
      // all requesters busy: round robin, one idle cycle between bursts
      do_reset();
      for (int i = 0; i < N; i++) src(i, 32, 8'hA0 + 8'(8'h11 * i), 0, 0);
      repeat (25) step(1'b0, 1'b0);
      check("t3_ncap", ncap, 20);
      for (int k = 0; k < 20; k++) begin
         check("t3_data", cap[k], 8'(8'hA0 + 8'h11 * ((k / 4) % 4)));
         check("t3_own", cap_own[k], (k / 4) % 4);
      end
      for (int b = 0; b < 5; b++) begin
         check("t3_gap_we", we_log[b*5], 0);
         check("t3_grant", gr_log[b*5+1], 4'b0001 << (b % 4));
      end
      // back-pressure holds the burst
      do_reset();
      src(1, 4, 8'h11, 1, 0);
      repeat (3) step(1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
      check("t4_ncap", ncap, 4);
      for (int k = 0; k < 4; k++) check("t4_data", cap[k], 8'h11 + 8'(k));
      for (int k = 3; k < 6; k++) begin
         check("t4_full_we", we_log[k], 0);
         check("t4_full_gr", gr_log[k], 4'b0010);
         check("t4_full_rdy", rdy_log[k], 0);
      end
      for (int k = 0; k < 9; k++) wv[k] = we_log[k];
      wv[9] = 1'b0;
      check("t4_we_pattern", wv, 10'b0011000110);
      // owner goes idle, arbitration wraps to req 0
      do_reset();
      src(3, 1, 8'h33, 0, 0);
      src(0, 1, 8'h0A, 0, 2);
      src(2, 1, 8'h2A, 0, 2);
      repeat (9) step(1'b0, 1'b0);
      check("t5_ncap", ncap, 3);
      check("t5_d0", cap[0], 8'h33);
      check("t5_d1", cap[1], 8'h0A);
      check("t5_d2", cap[2], 8'h2A);
      check("t5_release_we", we_log[2], 0);
      check("t5_nonowner_rdy", rdy_log[2], 4'b1000);
      check("t5_wrap_gr", gr_log[4], 4'b0001);
      check("t5_next_gr", gr_log[7], 4'b0100);
      // reset mid-burst restores the rr pointer
      do_reset();
      src(1, 1, 8'h51, 0, 0);
      src(2, 8, 8'h61, 1, 0);
      src(0, 1, 8'h0B, 0, 5);
      repeat (6) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("t6_rst_we", we_log[6], 0);
      check("t6_rst_rdy", rdy_log[6], 0);
      check("t6_rst_own", own_log[7], 0);
      check("t6_after_gr", gr_log[8], 4'b0001);
      check("t6_ncap", ncap, 4);
      check("t6_d1", cap[1], 8'h61);
      check("t6_d3", cap[3], 8'h0B);
`ifdef FIFO_ARB_STATS_EN
      do_reset();
      check("t7_rst_cnt", beat_count, 0);
      src(0, 5, 8'h70, 1, 0);
      repeat (8) step(1'b0, 1'b0);
      check("t7_cnt5", beat_count[15:0], 16'd5);
      check("t7_cnt_other", beat_count[63:16], 0);
      src(0, 3, 8'h80, 1, 0);
      cyc = 0;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("t7_cnt6", beat_count[15:0], 16'd6);
      stats_clear = 1'b1;
      step(1'b0, 1'b0);
      stats_clear = 1'b0;
      check("t7_clear_wins", beat_count[15:0], 16'd0);
      step(1'b0, 1'b0);
      check("t7_after_clear", beat_count[15:0], 16'd1);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
